// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift-register sequencer: command opcodes, FSM states and register width.
package shift_ctrl_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_EXCHANGE = 2'b00,
        OP_ROTATE   = 2'b01,
        OP_READ     = 2'b10,
        OP_CLEAR    = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        ROT,
        DONE
    } state_e;

    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

endpackage

// File: rtl/Shift_Register_PISO_PIPO.sv
// 8-bit PISO/PIPO register: sw=1 rotates left, else ps=1 loads pin, else shifts sin in at the LSB (MSB out first).
module Shift_Register_PISO_PIPO (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw,
    input  logic       ps,
    input  logic       sin,
    input  logic [7:0] pin,
    output logic       sout,
    output logic [7:0] pout
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pout <= '0;
        end else if (sw) begin
            pout <= {pout[6:0], pout[7]};
        end else if (ps) begin
            pout <= pin;
        end else begin
            pout <= {pout[6:0], sin};
        end
    end

    assign sout = pout[7];

endmodule

// File: rtl/bit_tick_gen.sv
// Serial bit-period divider: while enabled, emits a 1-cycle tick every CLK_DIV clocks.
module bit_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;

    assign tick = enable && (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div <= '0;
        end else if (enable) begin
            div <= tick ? '0 : div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/shift_reg_serial_ctrl.sv
// Command sequencer for the PISO/PIPO register: exchange, rotate, read and clear, with a response handshake.
module shift_reg_serial_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [2:0]        cmd_amt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              ser_in,
    output logic              ser_out,
    output logic              bit_strobe,
    output logic              busy,
    output logic              sr_sw,
    output logic              sr_ps,
    output logic              sr_sin,
    output logic [DATA_W-1:0] sr_pin,
    input  logic              sr_sout,
    input  logic [DATA_W-1:0] sr_pout
);

    state_e            state;
    op_e               op_q;
    logic [DATA_W-1:0] load_q;
    logic [2:0]        amt_q;
    logic [2:0]        rot_cnt;
    logic [3:0]        bit_cnt;
    logic              tick;
    logic              accept;

    assign accept = cmd_valid && cmd_ready;

    bit_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (state == SHIFT),
        .clear  (state == LOAD),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= OP_READ;
            load_q    <= '0;
            amt_q     <= '0;
            rot_cnt   <= '0;
            bit_cnt   <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= op_e'(cmd_op);
                        load_q    <= (op_e'(cmd_op) == OP_CLEAR) ? '0 : cmd_data;
                        amt_q     <= cmd_amt;
                        rot_cnt   <= '0;
                        bit_cnt   <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        case (op_e'(cmd_op))
                            OP_EXCHANGE, OP_CLEAR: state <= LOAD;
                            OP_ROTATE: begin
                                if (cmd_amt != 3'd0) begin
                                    state <= ROT;
                                end else begin
                                    state     <= DONE;
                                    rsp_valid <= 1'b1;
                                end
                            end
                            default: begin
                                state     <= DONE;
                                rsp_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                LOAD: begin
                    if (op_q == OP_CLEAR) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                ROT: begin
                    if (rot_cnt == amt_q - 3'd1) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end else begin
                        rot_cnt <= rot_cnt + 3'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The register has no enable, so every cycle that is not an operation reloads its own value.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sr_sw  = 1'b0;
        sr_ps  = 1'b1;
        sr_pin = sr_pout;
        case (state)
            LOAD:    sr_pin = load_q;
            SHIFT:   if (tick) sr_ps = 1'b0;
            ROT:     sr_sw = 1'b1;
            default: ;
        endcase
    end

    assign sr_sin     = ser_in;
    assign ser_out    = sr_sout;
    assign bit_strobe = (state == SHIFT) && tick;

    // The register is held throughout DONE, so its output is exactly the completion word.
    assign rsp_data = rsp_valid ? sr_pout : '0;

endmodule

// File: tb/tb_shift_reg_serial_ctrl.sv
// Scoreboard bench: two controller+register pairs (CLK_DIV 4 and 1), directed commands, decoupled response monitor.
module tb_shift_reg_serial_ctrl;
    import shift_ctrl_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         lat;
        int         acc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [2:0] cmd_amt;
    logic       rsp_ready;
    logic       ser_in;
    logic       sel;

    logic       cmd_ready4, rsp_valid4, ser_out4, bit_strobe4, busy4, sw4, ps4, sin4, sout4;
    logic [7:0] rsp_data4, pin4, pout4;
    logic       cmd_ready1, rsp_valid1, ser_out1, bit_strobe1, busy1, sw1, ps1, sin1, sout1;
    logic [7:0] rsp_data1, pin1, pout1;

    logic       cmd_ready, rsp_valid, ser_out, bit_strobe, busy;
    logic [7:0] rsp_data, pout;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] tx_byte, rx_byte;
    int         xfer_id;
    int         seen_id = 0;
    int         strobe_cnt = 0;
    bit         seen_valid = 0;

    shift_reg_serial_ctrl #(.CLK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid && !sel), .cmd_ready(cmd_ready4),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_amt(cmd_amt),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_data(rsp_data4),
        .ser_in(ser_in), .ser_out(ser_out4), .bit_strobe(bit_strobe4), .busy(busy4),
        .sr_sw(sw4), .sr_ps(ps4), .sr_sin(sin4), .sr_pin(pin4), .sr_sout(sout4), .sr_pout(pout4)
    );
    Shift_Register_PISO_PIPO reg4 (
        .clk(clk), .rst_n(~reset), .sw(sw4), .ps(ps4), .sin(sin4), .pin(pin4), .sout(sout4), .pout(pout4)
    );

    shift_reg_serial_ctrl #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid && sel), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_amt(cmd_amt),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1),
        .ser_in(ser_in), .ser_out(ser_out1), .bit_strobe(bit_strobe1), .busy(busy1),
        .sr_sw(sw1), .sr_ps(ps1), .sr_sin(sin1), .sr_pin(pin1), .sr_sout(sout1), .sr_pout(pout1)
    );
    Shift_Register_PISO_PIPO reg1 (
        .clk(clk), .rst_n(~reset), .sw(sw1), .ps(ps1), .sin(sin1), .pin(pin1), .sout(sout1), .pout(pout1)
    );

    // Bench view of whichever pair is currently selected.
    assign cmd_ready  = sel ? cmd_ready1  : cmd_ready4;
    assign rsp_valid  = sel ? rsp_valid1  : rsp_valid4;
    assign rsp_data   = sel ? rsp_data1   : rsp_data4;
    assign ser_out    = sel ? ser_out1    : ser_out4;
    assign bit_strobe = sel ? bit_strobe1 : bit_strobe4;
    assign busy       = sel ? busy1       : busy4;
    assign pout       = sel ? pout1       : pout4;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no DUT response within the cycle bound at t=%0t", name, $time);
    endtask

    // Serial line: present the rx bit for the pending strobe, and check the tx bit on each strobe.
    always @(negedge clk) begin
        if (xfer_id != seen_id) begin
            seen_id    = xfer_id;
            strobe_cnt = 0;
        end
        if (strobe_cnt < 8) ser_in = rx_byte[3'(7 - strobe_cnt)];
        if (!reset && bit_strobe) begin
            if (strobe_cnt < 8)
                check("ser_out_bit", 32'(ser_out), 32'(tx_byte[3'(7 - strobe_cnt)]));
            strobe_cnt++;
        end
    end

    // Response monitor: latency on first sight of rsp_valid, data on the handshake.
    always @(negedge clk) begin
        if (reset) begin
            seen_valid = 1'b0;
        end else if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                if (!seen_valid) begin
                    check("rsp_latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                    seen_valid = 1'b1;
                end
                if (rsp_ready) begin
                    check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
                    void'(sb.pop_front());
                    seen_valid = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic [2:0] amt,
                         input logic [7:0] rx, input logic [7:0] exp_data, input int exp_lat,
                         input bit track, output int acc);
        int n;
        n   = 0;
        acc = -1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_amt   = amt;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            timeout_fail("cmd_accept");
            cmd_valid = 1'b0;
            return;
        end
        if (op == OP_EXCHANGE) begin
            tx_byte = data;
            rx_byte = rx;
            xfer_id++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        acc = cyc;
        if (track) sb.push_back('{data: exp_data, lat: exp_lat, acc: cyc});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sb.size() != 0) && n < 1000);
        if (busy || sb.size() != 0) timeout_fail("wait_idle");
    endtask

    initial begin
        int acc1, acc2, k;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        cmd_amt   = 3'd0;
        rsp_ready = 1'b1;
        sel       = 1'b0;
        tx_byte   = 8'h00;
        rx_byte   = 8'h00;
        xfer_id   = 0;
        ser_in    = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_bit_strobe", 32'(bit_strobe), 32'd0);
        reset = 1'b0;

        // 1: EXCHANGE 0xA5 out, 0x3C in; 1 + 8*4 = 33 edges
        issue(OP_EXCHANGE, 8'hA5, 3'd0, 8'h3C, 8'h3C, 33, 1'b1, acc1);
        wait_idle();
        check("t1_strobe_count", 32'(strobe_cnt), 32'd8);

        // 2: CLEAR, ROTATE 0, EXCHANGE 0x81/0x81, ROTATE 3 -> 0x81 rotl 3 = 0x0C
        issue(OP_CLEAR, 8'hFF, 3'd0, 8'h00, 8'h00, 1, 1'b1, acc1);
        wait_idle();
        issue(OP_ROTATE, 8'h00, 3'd0, 8'h00, 8'h00, 0, 1'b1, acc1);
        wait_idle();
        issue(OP_EXCHANGE, 8'h81, 3'd0, 8'h81, 8'h81, 33, 1'b1, acc1);
        wait_idle();
        issue(OP_ROTATE, 8'h00, 3'd3, 8'h00, 8'h0C, 3, 1'b1, acc1);
        wait_idle();

        // 3: READ, then register must hold for 20 idle cycles
        issue(OP_READ, 8'h00, 3'd0, 8'h00, 8'h0C, 0, 1'b1, acc1);
        wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_hold", 32'(pout), 32'h0C);
        end

        // 4: response back-pressure; a stray CLEAR offered meanwhile must be ignored
        rsp_ready = 1'b0;
        issue(OP_READ, 8'h00, 3'd0, 8'h00, 8'h0C, 0, 1'b1, acc1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
            check("t4_rsp_data", 32'(rsp_data), 32'h0C);
            check("t4_cmd_ready", 32'(cmd_ready), 32'd0);
            if (i == 4) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_CLEAR;
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        issue(OP_READ, 8'h00, 3'd0, 8'h00, 8'h0C, 0, 1'b1, acc1);
        wait_idle();

        // 5: reset during the 4th bit period of an exchange, then a clean exchange
        issue(OP_EXCHANGE, 8'h5A, 3'd0, 8'hFF, 8'h00, 0, 1'b0, acc1);
        k = 0;
        for (int n = 0; n < 200 && k < 3; n++) begin
            @(negedge clk);
            if (bit_strobe) k++;
        end
        if (k < 3) timeout_fail("t5_third_strobe");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t5_bit_strobe", 32'(bit_strobe), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(OP_EXCHANGE, 8'h3C, 3'd0, 8'hC3, 8'hC3, 33, 1'b1, acc1);
        wait_idle();
        check("t5_strobe_count", 32'(strobe_cnt), 32'd8);

        // 6: CLK_DIV=1 back-to-back; accept gap = 9 latency + DONE cycle + IDLE cycle = 11 edges
        sel = 1'b1;
        issue(OP_EXCHANGE, 8'hFF, 3'd0, 8'h00, 8'h00, 9, 1'b1, acc1);
        issue(OP_EXCHANGE, 8'h00, 3'd0, 8'hFF, 8'hFF, 9, 1'b1, acc2);
        wait_idle();
        check("t6_accept_gap", 32'(acc2 - acc1), 32'd11);
        check("t6_strobe_count", 32'(strobe_cnt), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
